// File: rtl/matmul_pkg.sv
// Shared constants and state encoding for the matrix-multiply drain path.
package matmul_pkg;

  localparam int unsigned ACC_W   = 16;
  localparam int unsigned OUT_W   = 8;
  localparam int unsigned MAT_DIM = 4;
  localparam int unsigned ELEMS   = MAT_DIM * MAT_DIM;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } strm_state_t;

endpackage

// File: rtl/matmul_result_streamer_sync_fifo.sv
// Synchronous FIFO whose read word comes straight from storage flops; level
// tracks occupancy. Push when full and pop when empty are ignored.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign level   = cnt;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // DEPTH is a power of two, so pointer wrap is the natural overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/matmul_result_streamer.sv
// Drain stage: buffers accumulated results, saturates them to the output
// width and streams one MAT_DIM x MAT_DIM frame per start command.
module matmul_result_streamer #(
  parameter int unsigned ACC_W   = matmul_pkg::ACC_W,
  parameter int unsigned OUT_W   = matmul_pkg::OUT_W,
  parameter int unsigned MAT_DIM = matmul_pkg::MAT_DIM,
  parameter int unsigned DEPTH   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic [ACC_W-1:0]         in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [OUT_W-1:0]         out_data,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic                     frame_done,
  output logic                     sat_flag,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level
);

  import matmul_pkg::*;

  localparam int unsigned NWORDS = MAT_DIM * MAT_DIM;
  localparam int unsigned CNT_W  = $clog2(NWORDS) + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NWORDS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NWORDS - 1);
  localparam logic [ACC_W-1:0] SAT_MAX  = {{(ACC_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};

  strm_state_t      state_q, state_d;
  logic [CNT_W-1:0] in_cnt, out_cnt;
  logic             run;
  logic             push, pop, over;
  logic             fifo_full, fifo_empty;
  logic [OUT_W-1:0] sat_data, fifo_rdata;

  assign over     = (in_data > SAT_MAX);
  assign sat_data = over ? '1 : in_data[OUT_W-1:0];
  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

  sync_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (sat_data),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (pop && (out_cnt == CNT_LAST)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    run        = (state_q == RUN);
    busy       = (state_q != IDLE);
    frame_done = (state_q == DONE);
    in_ready   = run && !fifo_full && (in_cnt < CNT_FULL);
    out_valid  = run && !fifo_empty;
    out_data   = out_valid ? fifo_rdata : '0;
    out_last   = out_valid && (out_cnt == CNT_LAST);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_cnt   <= '0;
      out_cnt  <= '0;
      sat_flag <= 1'b0;
    end else if ((state_q == IDLE) && start) begin
      in_cnt   <= '0;
      out_cnt  <= '0;
      sat_flag <= 1'b0;
    end else begin
      if (push) begin
        in_cnt <= in_cnt + 1'b1;
        if (over) sat_flag <= 1'b1;
      end
      if (pop) out_cnt <= out_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_matmul_result_streamer.sv
// Directed self-checking bench for matmul_result_streamer.
module tb_matmul_result_streamer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic        out_last;
  logic        frame_done;
  logic        sat_flag;
  logic        busy;
  logic [3:0]  level;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] feed [20];
  logic [7:0]  expv [16];

  always #5 clk = ~clk;

  matmul_result_streamer #(
    .ACC_W   (16),
    .OUT_W   (8),
    .MAT_DIM (4),
    .DEPTH   (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .frame_done (frame_done),
    .sat_flag   (sat_flag),
    .busy       (busy),
    .level      (level)
  );

  // Starts a frame, feeds n_feed words from feed[], holds out_ready low for
  // `stall` cycles, optionally pulses start at cycle mid_start, and checks the
  // drained words against expv[].
  task automatic drive_frame(input int n_feed, input int stall, input int mid_start,
                             input string name);
    int fidx = 0;
    int oidx = 0;
    bit last_popped = 0;
    bit done_seen = 0;
    int n_acc;
    start = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || sat_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_start: busy=%b sat_flag=%b required busy=1 sat_flag=0", name, busy, sat_flag);
    end
    for (int c = 0; c < 300; c++) begin
      if (last_popped) begin
        n_checks++;
        if (frame_done !== 1'b1) begin
          n_fail++;
          $display("FAIL %s_frame_done: got %b required 1", name, frame_done);
        end
        done_seen = 1;
        break;
      end
      n_checks++;
      if (frame_done !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_early_done: frame_done=%b at cycle %0d required 0", name, frame_done, c);
      end
      start     = (c == mid_start);
      in_valid  = (fidx < n_feed);
      in_data   = in_valid ? feed[fidx] : '0;
      out_ready = (c >= stall);
      if (stall > 0 && c == stall - 1) begin
        n_checks++;
        if (level !== 4'd8 || in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== expv[0]) begin
          n_fail++;
          $display("FAIL %s_full: level=%0d in_ready=%b out_valid=%b out_data=%0d required 8/0/1/%0d",
                   name, level, in_ready, out_valid, out_data, expv[0]);
        end
      end
      if (fidx >= 16) begin
        n_checks++;
        if (in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL %s_overfeed: in_ready=%b after %0d pushes required 0", name, in_ready, fidx);
        end
      end
      if (in_valid && in_ready) fidx++;
      if (out_valid) begin
        n_checks++;
        if (oidx > 15 || out_data !== expv[oidx] || out_last !== (oidx == 15)) begin
          n_fail++;
          $display("FAIL %s_word%0d: data=%0d last=%b required data=%0d last=%b",
                   name, oidx, out_data, out_last, (oidx > 15) ? 8'd0 : expv[oidx], (oidx == 15));
        end
        if (out_ready) begin
          if (oidx == 15) last_popped = 1;
          oidx++;
        end
      end
      @(posedge clk); #1;
    end
    n_acc = (n_feed < 16) ? n_feed : 16;
    n_checks++;
    if (!done_seen || oidx != 16 || fidx != n_acc) begin
      n_fail++;
      $display("FAIL %s_count: done=%0d popped=%0d accepted=%0d required 1/16/%0d",
               name, done_seen, oidx, fidx, n_acc);
    end
    start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || frame_done !== 1'b0 || level !== 4'd0) begin
      n_fail++;
      $display("FAIL %s_idle: busy=%b out_valid=%b frame_done=%b level=%0d required 0/0/0/0",
               name, busy, out_valid, frame_done, level);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b1; in_valid = 1'b1; in_data = 16'h1234; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({out_valid, out_last, frame_done, sat_flag, busy, in_ready} !== 6'b0 ||
        out_data !== 8'd0 || level !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_hold: v/l/d/s/b/r=%b data=%0d level=%0d required all 0",
               {out_valid, out_last, frame_done, sat_flag, busy, in_ready}, out_data, level);
    end
    start = 1'b0;
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({out_valid, out_last, frame_done, sat_flag, busy, in_ready} !== 6'b0 ||
        out_data !== 8'd0 || level !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_release: v/l/d/s/b/r=%b data=%0d level=%0d required all 0",
               {out_valid, out_last, frame_done, sat_flag, busy, in_ready}, out_data, level);
    end
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_nominal();
    logic [7:0] row [4];
    row[0] = 8'd40; row[1] = 8'd27; row[2] = 8'd14; row[3] = 8'd8;
    for (int i = 0; i < 20; i++) feed[i] = 16'(row[i % 4]);
    for (int i = 0; i < 16; i++) expv[i] = row[i % 4];
    drive_frame(16, 0, -1, "nominal");
    n_checks++;
    if (sat_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL nominal_sat: sat_flag=%b required 0", sat_flag);
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 16; i++) begin
      feed[i] = 16'(i * 13 + 5);
      expv[i] = 8'(i * 13 + 5);
    end
    drive_frame(16, 12, -1, "backpressure");
  endtask

  task automatic test_saturation();
    logic [15:0] pat_in  [4];
    logic [7:0]  pat_out [4];
    pat_in[0]  = 16'd300; pat_in[1]  = 16'd255; pat_in[2]  = 16'd256; pat_in[3]  = 16'd0;
    pat_out[0] = 8'd255;  pat_out[1] = 8'd255;  pat_out[2] = 8'd255;  pat_out[3] = 8'd0;
    for (int i = 0; i < 16; i++) begin
      feed[i] = pat_in[i % 4];
      expv[i] = pat_out[i % 4];
    end
    drive_frame(16, 0, -1, "saturation");
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (sat_flag !== 1'b1) begin
      n_fail++;
      $display("FAIL saturation_sticky: sat_flag=%b required 1", sat_flag);
    end
  endtask

  task automatic test_overfeed();
    for (int i = 0; i < 20; i++) feed[i] = 16'(i + 1);
    for (int i = 0; i < 16; i++) expv[i] = 8'(i + 1);
    drive_frame(20, 0, 5, "overfeed");
  endtask

  task automatic test_reset_midframe();
    int pushed = 0;
    start = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 20 && pushed < 5; c++) begin
      in_valid = 1'b1;
      in_data  = 16'(500 + pushed);
      if (in_ready) pushed++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || level !== 4'd0 || out_valid !== 1'b0 || sat_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset: pushed=%0d busy=%b level=%0d out_valid=%b sat=%b required 5/0/0/0/0",
               pushed, busy, level, out_valid, sat_flag);
    end
    #2 rst = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin
      feed[i] = 16'(i * 16);
      expv[i] = 8'(i * 16);
    end
    drive_frame(16, 0, -1, "post_reset");
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    test_reset();
    test_nominal();
    test_backpressure();
    test_saturation();
    test_overfeed();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
